// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// State encoding, default sizing and a one-hot helper.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int WIDTH_DEF   = 8;
   localparam int MAX_REQ     = 8;

   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register write arbiter.
// master = producers, slave = arbiter.
interface reg_write_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF
);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       ack;

   modport master (
      output req,
      output wdata,
      input  gnt,
      input  ack
   );

   modport slave (
      input  req,
      input  wdata,
      output gnt,
      output ack
   );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first live request at or above ptr,
// wrapping to the lowest live request below ptr.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   logic [NUM_REQ-1:0] live;
   logic               hi_v;
   logic [ID_W-1:0]    hi;
   logic [ID_W-1:0]    lo;

   assign live = req & ~mask;

   // Descending scan: the last hit is the lowest index in each range.
   always_comb begin
      hi_v  = 1'b0;
      hi    = '0;
      lo    = '0;
      valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (live[i]) begin
            valid = 1'b1;
            lo    = ID_W'(i);
            if (ID_W'(i) >= ptr) begin
               hi_v = 1'b1;
               hi   = ID_W'(i);
            end
         end
      end
   end

   assign idx = hi_v ? hi : lo;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled WIDTH-bit register between requesters.
// Optional REG_ARB_LOCK_EN adds a per-requester lock that keeps the grant.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   parameter  int WIDTH   = WIDTH_DEF,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_write_arbiter_if.slave bus,
`ifdef REG_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0] lock,
`endif
   output logic [ID_W-1:0]  owner,
   output logic             busy,
   output logic             reg_en,
   output logic [WIDTH-1:0] reg_d,
   output logic [WIDTH-1:0] reg_q
);

   state_t             state, state_n;
   logic [NUM_REQ-1:0] gnt_q, gnt_n;
   logic [ID_W-1:0]    owner_q, owner_n;
   logic [ID_W-1:0]    ptr_q, ptr_n, ptr_inc;
   logic [WIDTH-1:0]   d_q, d_n;
   logic [WIDTH-1:0]   q_q, q_n;
   logic [NUM_REQ-1:0] own_oh;
   logic [NUM_REQ-1:0] pick_mask;
   logic [ID_W-1:0]    pick_ptr, pick_idx;
   logic               pick_valid;
   logic [WIDTH-1:0]   pick_data;
   logic               hold;

   assign own_oh  = NUM_REQ'(onehot(32'(owner_q)));
   assign ptr_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

   // During WRITE the search already starts past the current owner.
   assign pick_ptr  = (state == WRITE) ? ptr_inc : ptr_q;
   assign pick_mask = (state == WRITE) ? own_oh : '0;

   rr_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .req  (bus.req),
      .mask (pick_mask),
      .ptr  (pick_ptr),
      .valid(pick_valid),
      .idx  (pick_idx)
   );

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == ID_W'(i)) pick_data = bus.wdata[i*WIDTH +: WIDTH];
      end
   end

`ifdef REG_ARB_LOCK_EN
   logic [WIDTH-1:0] own_data;

   always_comb begin
      own_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) own_data = bus.wdata[i*WIDTH +: WIDTH];
      end
   end

   assign hold = |(lock & bus.req & own_oh);
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_n = state;
      gnt_n   = gnt_q;
      owner_n = owner_q;
      ptr_n   = ptr_q;
      d_n     = d_q;
      q_n     = q_q;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n = GRANT;
               gnt_n   = NUM_REQ'(onehot(32'(pick_idx)));
               owner_n = pick_idx;
               d_n     = pick_data;
            end
         end
         GRANT: state_n = WRITE;
         WRITE: begin
            q_n = d_q;
            if (hold) begin
               state_n = GRANT;
`ifdef REG_ARB_LOCK_EN
               d_n     = own_data;
`endif
            end else begin
               ptr_n = ptr_inc;
               if (pick_valid) begin
                  state_n = GRANT;
                  gnt_n   = NUM_REQ'(onehot(32'(pick_idx)));
                  owner_n = pick_idx;
                  d_n     = pick_data;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         d_q     <= '0;
         q_q     <= '0;
      end else begin
         state   <= state_n;
         gnt_q   <= gnt_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         d_q     <= d_n;
         q_q     <= q_n;
      end
   end

   assign bus.gnt = gnt_q;
   assign bus.ack = (state == WRITE) ? own_oh : '0;
   assign owner   = owner_q;
   assign busy    = (state != IDLE);
   assign reg_en  = (state == WRITE);
   assign reg_d   = d_q;
   assign reg_q   = q_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_reg_write_arbiter;

   localparam int NR = 4;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

   logic [1:0]   owner;
   logic         busy;
   logic         reg_en;
   logic [W-1:0] reg_d;
   logic [W-1:0] reg_q;
`ifdef REG_ARB_LOCK_EN
   logic [NR-1:0] lock = '0;
`endif

   reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
`ifdef REG_ARB_LOCK_EN
      .lock  (lock),
`endif
      .owner (owner),
      .busy  (busy),
      .reg_en(reg_en),
      .reg_d (reg_d),
      .reg_q (reg_q)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Model: a write transaction is either absent, granted (waiting) or writing.
   int           m_stage = 0;
   int           m_owner = 0;
   int           m_ptr = 0;
   logic [W-1:0] m_data = '0;
   logic [W-1:0] m_q = '0;
   int           mw;
   logic [NR-1:0] mr;

   function automatic int pick(input logic [NR-1:0] r, input int from);
      for (int k = 0; k < NR; k++) begin
         if (r[(from + k) % NR]) return (from + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] slice(input int i);
      return bus.wdata[i*W +: W];
   endfunction

   function automatic bit locked();
`ifdef REG_ARB_LOCK_EN
      return lock[m_owner] && bus.req[m_owner];
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stage = 0;
         m_owner = 0;
         m_ptr   = 0;
         m_data  = '0;
         m_q     = '0;
      end else begin
         case (m_stage)
            0: begin
               mw = pick(bus.req, m_ptr);
               if (mw >= 0) begin
                  m_owner = mw;
                  m_data  = slice(mw);
                  m_stage = 1;
               end
            end
            1: m_stage = 2;
            default: begin
               m_q = m_data;
               if (locked()) begin
                  m_data  = slice(m_owner);
                  m_stage = 1;
               end else begin
                  m_ptr = (m_owner + 1) % NR;
                  mr = bus.req;
                  mr[m_owner] = 1'b0;
                  mw = pick(mr, m_ptr);
                  if (mw >= 0) begin
                     m_owner = mw;
                     m_data  = slice(mw);
                     m_stage = 1;
                  end else begin
                     m_stage = 0;
                  end
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      check("gnt", bus.gnt, (m_stage != 0) ? (32'd1 << m_owner) : 32'd0);
      check("ack", bus.ack, (m_stage == 2) ? (32'd1 << m_owner) : 32'd0);
      check("owner", owner, m_owner);
      check("busy", busy, m_stage != 0);
      check("reg_en", reg_en, m_stage == 2);
      check("reg_d", reg_d, m_data);
      check("reg_q", reg_q, m_q);
   end

   int cyc = 0;
   int ack_idx[$];
   int ack_cyc[$];
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NR; i++) begin
            if (bus.ack[i]) begin
               ack_idx.push_back(i);
               ack_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic do_write(input int i, input logic [W-1:0] d);
      bit seen;
      seen = 1'b0;
      bus.wdata[i*W +: W] = d;
      bus.req[i] = 1'b1;
      for (int c = 0; c < 12 && !seen; c++) begin
         @(negedge clk);
         if (bus.ack[i]) begin
            seen = 1'b1;
            bus.req[i] = 1'b0;
         end
      end
      check("write_done", seen, 1'b1);
      bus.req[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [NR-1:0] drop_next = '0;
   int            nack;
   int            exp_fair[5] = '{0, 1, 2, 3, 0};
   int            exp_lock[5] = '{0, 1, 1, 1, 0};

   initial begin
      bus.req   = '0;
      bus.wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_q", reg_q, 8'h00);
      check("rst_gnt", bus.gnt, 4'b0000);
      rst_n = 1'b1;

      // single write by requester 2
      bus.req = 4'b0100;
      bus.wdata[2*W +: W] = 8'h3C;
      @(negedge clk);
      check("sw_gnt", bus.gnt, 4'b0100);
      check("sw_en0", reg_en, 1'b0);
      @(negedge clk);
      check("sw_en1", reg_en, 1'b1);
      check("sw_ack", bus.ack, 4'b0100);
      bus.req = '0;
      @(negedge clk);
      check("sw_q", reg_q, 8'h3C);
      check("sw_idle", busy, 1'b0);

      // reset in the middle of a write
      bus.req = 4'b0001;
      bus.wdata[0 +: W] = 8'hA5;
      repeat (2) @(negedge clk);
      check("mw_d", reg_d, 8'hA5);
      check("mw_en", reg_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mw_q", reg_q, 8'h00);
      check("mw_ack", bus.ack, 4'b0000);
      check("mw_gnt", bus.gnt, 4'b0000);
      check("mw_dz", reg_d, 8'h00);
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // wrap: serve 2 so the pointer sits at 3, then 3 and 0 compete
      do_write(2, 8'h5A);
      ack_idx.delete();
      ack_cyc.delete();
      bus.wdata[0 +: W] = 8'h01;
      bus.wdata[3*W +: W] = 8'h03;
      bus.req = 4'b1001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
      end
      check("wrap_n", ack_idx.size(), 2);
      if (ack_idx.size() >= 2) begin
         check("wrap_0", ack_idx[0], 3);
         check("wrap_1", ack_idx[1], 0);
      end
      check("wrap_q", reg_q, 8'h01);

      // data is latched at grant
      bus.wdata[1*W +: W] = 8'h11;
      bus.req[1] = 1'b1;
      @(negedge clk);
      bus.wdata[1*W +: W] = 8'h22;
      @(negedge clk);
      check("stale_ack", bus.ack, 4'b0010);
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("stale_q", reg_q, 8'h11);

      // fairness with all four requesters re-asserting
      pulse_reset();
      ack_idx.delete();
      ack_cyc.delete();
      bus.req = 4'b1111;
      nack = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (bus.ack[i]) begin
               bus.req[i] = 1'b0;
               nack++;
            end else if (!bus.req[i] && nack < 5) begin
               bus.req[i] = 1'b1;
            end
         end
         if (nack >= 5) bus.req = '0;
      end
      check("fair_n", ack_idx.size() >= 5, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (ack_idx.size() > k) check("fair_order", ack_idx[k], exp_fair[k]);
         if (ack_idx.size() > k && k > 0)
            check("fair_gap", ack_cyc[k] - ack_cyc[k-1], 2);
      end

`ifdef REG_ARB_LOCK_EN
      pulse_reset();
      ack_idx.delete();
      ack_cyc.delete();
      bus.req = 4'b0011;
      lock = 4'b0010;
      nack = 0;
      for (int c = 0; c < 40 && bus.req != 0; c++) begin
         @(negedge clk);
         if (bus.ack[1]) begin
            nack++;
            if (nack == 3) lock = '0;
         end
         if (bus.ack[0] && nack >= 3) bus.req = '0;
      end
      bus.req = '0;
      repeat (4) @(negedge clk);
      check("lock_n", ack_idx.size() >= 5, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (ack_idx.size() > k) check("lock_order", ack_idx[k], exp_lock[k]);
      end
`endif

      // random traffic, one asynchronous reset in the middle
      pulse_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (drop_next[i]) begin
               bus.req[i] = 1'b0;
               drop_next[i] = 1'b0;
            end else if (bus.ack[i]) begin
               if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
               else drop_next[i] = 1'b1;
            end else if (!bus.req[i] && $urandom_range(3) == 0) begin
               bus.req[i] = 1'b1;
            end
            if ($urandom_range(2) == 0) bus.wdata[i*W +: W] = W'($urandom);
         end
`ifdef REG_ARB_LOCK_EN
         if ($urandom_range(7) == 0) lock = NR'($urandom);
`endif
         if (c == 1500) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end
      bus.req = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one enabled, resettable WIDTH-bit register (a bank of gated-enable D flip-flops) between NUM_REQ write requesters.
- Round-robin arbitration; sequences register enable and data through a 3-state FSM, one write per grant.
- Sits between producer blocks and the shared register in the catalog's parameterized storage path; drives reg_en/reg_d and holds the register state reg_q.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- ID_W, $clog2(NUM_REQ), width of owner index (derived localparam, not overridable)

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester write request, level, held until ack
- wdata  in  NUM_REQ*WIDTH  packed write data, slice i belongs to req[i]
- gnt  out  NUM_REQ  registered one-hot grant, all-zero when idle
- ack  out  NUM_REQ  one-hot write-complete pulse, one cycle
- owner  out  ID_W  index of current/last granted requester
- busy  out  1  high in GRANT or WRITE
- reg_en  out  1  register write enable, high only in WRITE
- reg_d  out  WIDTH  latched write data presented to the register
- reg_q  out  WIDTH  current register value

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, ack=0, owner=0, busy=0, reg_en=0, reg_d=0, reg_q=0, rr pointer=0.
- States: IDLE, GRANT, WRITE.
- IDLE: if any req at the edge -> GRANT; winner = first set req[i] searching from pointer upward, wrapping modulo NUM_REQ. Same edge: gnt<=onehot(winner), owner<=winner, reg_d<=wdata slice of winner.
- GRANT: one cycle, gnt held, reg_en=0. -> WRITE unconditionally.
- WRITE: reg_en=1, ack[owner]=1 (combinational from state, one cycle). At the leaving edge reg_q<=reg_d; pointer<=owner+1 (wrap). Next state: GRANT if any req other than req[owner] is set (req[owner] masked this edge), with new winner latched as in IDLE; else IDLE with gnt<=0.
- Latency: req rising before edge 0 with arbiter idle -> gnt at edge 0, reg_en/ack in cycle after edge 1, reg_q updated at edge 2. Back-to-back write throughput: one write per 2 cycles.
- Requester must drop req by the edge after its ack or it is re-arbitrated as a new request.
- req/wdata changes while granted: ignored; data latched at grant.
- Requests arriving during GRANT/WRITE wait; no grant change until the WRITE exit edge.
- Single requester continuously asserting: served, then masked for one edge, then re-granted from IDLE.
- Reset mid-WRITE: write aborted, reg_q=0, no ack.
- NUM_REQ not power of two: pointer wraps at NUM_REQ-1 -> 0, never holds an invalid index.

Optional Feature:
- Macro REG_ARB_LOCK_EN. Defined: adds input lock [NUM_REQ]. If lock[owner] is high at the WRITE exit edge and req[owner] is high, next state GRANT with the same owner (no mask, no pointer advance), reg_d re-latched from its wdata. Lock ignored in IDLE/GRANT.
- Undefined: port absent, always rotate as above.

Decomposition:
- Package reg_arb_pkg: state enum (IDLE=2'd0, GRANT=2'd1, WRITE=2'd2), default NUM_REQ/WIDTH constants, function onehot(idx).
- One sub-module: rr_pick, combinational round-robin picker (req, mask, pointer -> valid, index). FSM, data latch and reg_q flop stay in the top.

Test Plan:
- Reset: hold rst_n=0 mid-WRITE with reg_d=8'hA5 -> all outputs 0 immediately, no ack, reg_q=8'h00.
- Single write: req=4'b0100, wdata[2]=8'h3C -> gnt=4'b0100 at edge 1, reg_en+ack[2] next cycle, reg_q=8'h3C at edge 3, then IDLE.
- Fairness: req=4'b1111 held (each drops after own ack, re-asserts next cycle) -> ack order 0,1,2,3,0 at one ack per 2 cycles.
- Wrap: pointer=3, req=4'b1001 -> req[3] served first, then req[0]; pointer wraps to 0.
- Stale-data: change wdata[1] from 8'h11 to 8'h22 during GRANT -> reg_q=8'h11.
- Lock (REG_ARB_LOCK_EN): lock[1]=1, req=4'b0011 held -> three consecutive writes by requester 1; lock drop -> requester 0 served next.
